// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
//   Programmable serial pattern detector with a saturating match counter.
//   Valid serial bits are shifted into a history register. A match fires when
//   at least PAT_W bits have been collected since the last restart point and
//   the newest PAT_W bits equal the programmed pattern (oldest bit in the MSB).
//   Detection can be overlapping, where the window stays full after a match,
//   or non-overlapping, where the window restarts empty after a match.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   CNT_W    match counter width (1..16)
//   PAT_RST  pattern loaded by reset
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   in          serial data bit
//   in_valid    in is sampled only when high
//   pat_load    load pat_in as the new pattern and restart the window
//   pat_in      new pattern, bit PAT_W-1 is the oldest bit of the sequence
//   overlap_en  1 = overlapping detection, 0 = non-overlapping
//   clr_cnt     synchronous clear of match_cnt
//   q           registered match flag, one cycle after the completing bit
//   match_cnt   saturating count of matches
//   cnt_sat     high while match_cnt is at its maximum value
// ---------------------------------------------------------------------------
module seq_det_prog #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = {PAT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             clr_cnt,
    output logic             q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [PAT_W-1:0]  hist_reg;
    logic [PAT_W-1:0]  hist_next;
    logic [PAT_W-1:0]  pat_reg;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_inc;
    logic [FILL_W-1:0] fill_next;
    logic              match;
    logic              q_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;

    // Candidate window after shifting in the current bit. The fill count
    // saturates at PAT_W so that, once full, every further bit is a candidate.
    always_comb begin
        hist_next = {hist_reg[PAT_W-2:0], in};
        fill_inc  = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_ONE;
        match     = in_valid && !pat_load && (fill_inc == FILL_FULL)
                    && (hist_next == pat_reg);
        // Non-overlapping mode restarts the window empty after a match; the
        // history bits stay stale but can never be compared until PAT_W new
        // bits have replaced them.
        fill_next = (match && !overlap_en) ? '0 : fill_inc;
    end

    // Counter: clear wins over increment, but a match in the clear cycle
    // is still counted. Saturates instead of wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr_cnt) begin
            cnt_next = match ? CNT_ONE : '0;
        end else if (match && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // Window state and pattern. pat_load takes priority over in_valid and
    // discards the bit presented in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg <= '0;
            fill_reg <= '0;
            pat_reg  <= PAT_RST;
        end else if (pat_load) begin
            hist_reg <= '0;
            fill_reg <= '0;
            pat_reg  <= pat_in;
        end else if (in_valid) begin
            hist_reg <= hist_next;
            fill_reg <= fill_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg   <= 1'b0;
            cnt_reg <= '0;
        end else begin
            q_reg   <= match;
            cnt_reg <= cnt_next;
        end
    end

    assign q         = q_reg;
    assign match_cnt = cnt_reg;
    assign cnt_sat   = (cnt_reg == CNT_MAX);

endmodule

// File: tb/tb_seq_det_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_det_prog
//   Drives two detectors (8-bit and 2-bit match counters, reset pattern 1011)
//   from the same stimulus. A queue-based model of the bit window predicts
//   q, match_cnt and cnt_sat; a compare process checks both detectors against
//   it on every falling edge, and directed scenarios add hand-computed checks.
// ---------------------------------------------------------------------------
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       in;
    logic       in_valid;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       overlap_en;
    logic       clr_cnt;

    logic       q8, sat8, q2, sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_det_prog #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1011)) dut8 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
        .clr_cnt(clr_cnt), .q(q8), .match_cnt(cnt8), .cnt_sat(sat8)
    );

    seq_det_prog #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1011)) dut2 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
        .clr_cnt(clr_cnt), .q(q2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mq holds the valid bits collected since the last restart point (reset,
    // pattern load, or a non-overlapping match), trimmed to the newest 4.
    bit         mq[$];
    logic [3:0] mpat  = 4'b1011;
    int         mcnt  = 0;
    bit         exp_q = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        bit         m;
        logic [3:0] w;
        if (rst) begin
            mq.delete();
            mpat  = 4'b1011;
            mcnt  = 0;
            exp_q = 1'b0;
        end else begin
            m = 1'b0;
            if (pat_load) begin
                mpat = pat_in;
                mq.delete();
            end else if (in_valid) begin
                mq.push_back(in);
                if (mq.size() > 4) void'(mq.pop_front());
                if (mq.size() == 4) begin
                    w = 4'b0;
                    foreach (mq[k]) w = {w[2:0], mq[k]};
                    m = (w == mpat);
                end
                if (m && !overlap_en) mq.delete();
            end
            if (clr_cnt) mcnt = m ? 1 : 0;
            else         mcnt = mcnt + (m ? 1 : 0);
            exp_q = m;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int e8, e2;
        e8 = (mcnt > 255) ? 255 : mcnt;
        e2 = (mcnt > 3) ? 3 : mcnt;
        check("q8",   32'(q8),   32'(exp_q));
        check("q2",   32'(q2),   32'(exp_q));
        check("cnt8", 32'(cnt8), e8);
        check("cnt2", 32'(cnt2), e2);
        check("sat8", 32'(sat8), (e8 == 255) ? 1 : 0);
        check("sat2", 32'(sat2), (e2 == 3) ? 1 : 0);
    end

    // ---------------- stimulus helpers ----------------
    // Apply one cycle of inputs; returns just after the sampling edge so the
    // registered outputs reflect that cycle.
    task automatic step(input bit r, input bit v, input bit b, input bit ld,
                        input logic [3:0] pi, input bit clr);
        rst      = r;
        in_valid = v;
        in       = b;
        pat_load = ld;
        pat_in   = pi;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input bit b);
        step(1'b0, 1'b1, b, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    // load a pattern and clear the counter in the same cycle
    task automatic load(input logic [3:0] p);
        step(1'b0, 1'b0, 1'b0, 1'b1, p, 1'b1);
    endtask

    initial begin
        int s7[7]     = '{1, 0, 1, 1, 0, 1, 1};
        int q_ov[7]   = '{0, 0, 0, 1, 0, 0, 1};
        int q_nov[7]  = '{0, 0, 0, 1, 0, 0, 0};
        int s_ld[4]   = '{0, 1, 1, 0};
        int q_ld[4]   = '{0, 0, 0, 1};

        rst = 1'b1; in = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
        pat_in = 4'b0; overlap_en = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q",    32'(q8),   0);
        check("rst_cnt",  32'(cnt8), 0);
        check("rst_sat2", 32'(sat2), 0);
        idle();
        check("release_q", 32'(q8), 0);

        // overlapping: matches after bits 4 and 7
        overlap_en = 1'b1;
        load(4'b1011);
        foreach (s7[i]) begin
            bit_in(s7[i][0]);
            check($sformatf("ov_q_bit%0d", i + 1), 32'(q8), q_ov[i]);
        end
        check("ov_cnt", 32'(cnt8), 2);

        // non-overlapping: only the match after bit 4
        overlap_en = 1'b0;
        load(4'b1011);
        foreach (s7[i]) begin
            bit_in(s7[i][0]);
            check($sformatf("nov_q_bit%0d", i + 1), 32'(q8), q_nov[i]);
        end
        check("nov_cnt", 32'(cnt8), 1);

        // gaps in in_valid hold the history
        overlap_en = 1'b1;
        load(4'b1011);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        repeat (3) begin
            idle();
            check("gap_q", 32'(q8), 0);
        end
        bit_in(1'b1);
        check("gap_final_q", 32'(q8), 1);

        // reload mid-stream discards stale bits
        load(4'b1011);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        load(4'b0110);
        foreach (s_ld[i]) begin
            bit_in(s_ld[i][0]);
            check($sformatf("ld_q_bit%0d", i + 1), 32'(q8), q_ld[i]);
        end

        // saturation of the 2-bit counter, then clear with a coincident match
        load(4'b1011);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        repeat (4) begin
            bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        end
        check("sat_cnt2", 32'(cnt2), 3);
        check("sat_flag2", 32'(sat2), 1);
        check("sat_cnt8", 32'(cnt8), 5);
        bit_in(1'b0); bit_in(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        check("clrm_cnt2", 32'(cnt2), 1);
        check("clrm_sat2", 32'(sat2), 0);
        check("clrm_cnt8", 32'(cnt8), 1);

        // reset mid-sequence wipes the history
        load(4'b1011);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("midrst_cnt", 32'(cnt8), 0);
        idle();
        check("midrst_rel_q", 32'(q8), 0);
        bit_in(1'b1);
        check("midrst_first_q", 32'(q8), 0);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        check("midrst_final_q", 32'(q8), 1);

        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
SEQ_DET_PROG -- requirements
Module: seq_det_prog

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern length in bits; legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match counter width; legal range 1..16.
REQ-003 The block SHALL have parameter PAT_RST, default {PAT_W{1'b1}}, giving the pattern loaded at reset.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in  input  1  serial data bit.
REQ-007 in_valid  input  1  in is sampled only when high.
REQ-008 pat_load  input  1  loads pat_in as the new pattern.
REQ-009 pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the oldest bit of the sequence.
REQ-010 overlap_en  input  1  1 = overlapping detection; 0 = non-overlapping.
REQ-011 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-012 q  output  1  registered match flag (Moore).
REQ-013 match_cnt  output  CNT_W  saturating count of matches.
REQ-014 cnt_sat  output  1  high while match_cnt equals 2^CNT_W-1.

Function
REQ-015 The block SHALL keep a PAT_W-bit history register, hist, updated on each valid cycle as hist_n = {hist[PAT_W-2:0], in}.
REQ-016 The block SHALL keep a fill counter of width clog2(PAT_W+1), updated on each valid cycle as fill_n = min(fill+1, PAT_W).
REQ-017 The internal match SHALL be asserted when in_valid=1, pat_load=0, fill_n==PAT_W and hist_n==pattern.
REQ-018 q SHALL be registered from match, so it is high for exactly one cycle, in the cycle after the completing bit is sampled; latency is 1.
REQ-019 q SHALL be 0 in any cycle following a non-valid cycle or a pat_load cycle.
REQ-020 When a match occurs with overlap_en=1, fill SHALL remain PAT_W, so a following bit can complete a further match.
REQ-021 When a match occurs with overlap_en=0, fill SHALL become 0, so the next match needs PAT_W fresh valid bits.
REQ-022 overlap_en SHALL be sampled in the cycle of the match; changing it mid-stream SHALL NOT clear hist or fill.
REQ-023 pat_load=1 SHALL:
- write pat_in into the pattern register;
- clear fill and hist to 0;
- discard in for that cycle;
- take priority over in_valid.
REQ-024 When in_valid=0 and pat_load=0, hist, fill and pattern SHALL hold.
REQ-025 match_cnt SHALL increment by 1 on each match and hold at 2^CNT_W-1 (no wrap).
REQ-026 cnt_sat SHALL be the combinational compare match_cnt==2^CNT_W-1.
REQ-027 clr_cnt=1 SHALL set match_cnt to 0, or to 1 if a match occurs in the same cycle.
REQ-028 With PAT_W=2, PAT_RST=2'b11 and overlap_en=1, q SHALL be high in the cycle after every second-or-later consecutive 1.

Reset
REQ-029 While rst=1, the block SHALL hold: q=0, match_cnt=0, cnt_sat=0, hist=0, fill=0, pattern=PAT_RST.
REQ-030 Reset SHALL take effect immediately, including mid-sequence; the first valid bit after release SHALL count as fill=1.
REQ-031 Release of rst SHALL NOT, by itself, cause a match or change q.

Verification (PAT_W=4, CNT_W=8, pattern loaded as 4'b1011)
REQ-032 overlap_en=1, valid stream 1,0,1,1,0,1,1 -> q high the cycle after bits 4 and 7; match_cnt=2.
REQ-033 overlap_en=0, same stream -> q high only the cycle after bit 4; match_cnt=1.
REQ-034 Stream 1,0,1 then in_valid=0 for 3 cycles, then 1 -> hist held; q high the cycle after the final bit.
REQ-035 pat_load with pat_in=4'b0110 after bits 1,0,1, followed by 0,1,1,0 -> no match from stale bits; q high the cycle after the last 0.
REQ-036 CNT_W=2, 5 matches -> match_cnt sticks at 3 with cnt_sat=1; clr_cnt together with a 6th match -> match_cnt=1, cnt_sat=0.
REQ-037 rst pulsed after bits 1,0,1, followed by 1,0,1,1 -> q=0 after the first 1, and q high the cycle after the final 1.
